// File: rtl/prince_sbox_cms_pipe.sv
// Two-stage, two-share CMS implementation of the PRINCE S-box with valid/ready flow control.
// Optional output refresh with rnd is enabled by defining PRINCE_SBOX_CMS_REFRESH_EN.
module prince_sbox_cms_pipe #(
    parameter int LANES      = 16,
    parameter int STALL_KEEP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*LANES-1:0]   in_sh1,
    input  logic [4*LANES-1:0]   in_sh2,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   rnd,
    output logic [4*LANES-1:0]   out_sh1,
    output logic [4*LANES-1:0]   out_sh2,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // S-box table, nibble i holds S(i).
    localparam logic [63:0] SBOX = 64'h4D5E_0876_19CA_23FB;

    // Algebraic normal form coefficient of monomial u in output bit j.
    function automatic logic anf_coef(input logic [1:0] j, input logic [3:0] u);
        logic       c;
        logic [3:0] vv;
        c = 1'b0;
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            if ((vv & ~u) == 4'b0000) begin
                c = c ^ SBOX[{vv, j}];
            end
        end
        return c;
    endfunction

    // Term t picks share sel[i] of each variable ({w,z,y,x}); each monomial expansion
    // lands in exactly one term, with absent variables pinned to share 1.
    function automatic logic cms_term(input logic [1:0] j, input logic [3:0] t,
                                      input logic [3:0] s1, input logic [3:0] s2);
        logic [3:0] sel;
        logic [3:0] v;
        logic [3:0] uu;
        logic       acc;
        logic       p;
        logic       ok;
        sel = {t[0], t[1], t[2], t[3]};
        v   = (s1 & ~sel) | (s2 & sel);
        acc = 1'b0;
        for (int u = 0; u < 16; u++) begin
            uu = 4'(u);
            if (anf_coef(j, uu)) begin
                p  = 1'b1;
                ok = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (uu[i]) begin
                        p = p & v[i];
                    end else if (sel[i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    acc = acc ^ p;
                end
            end
        end
        return acc;
    endfunction

    logic [LANES-1:0][3:0][15:0] w_term;
    logic [LANES-1:0][3:0][15:0] r_term;
    logic [4*LANES-1:0]          w_c1;
    logic [4*LANES-1:0]          w_c2;
    logic [4*LANES-1:0]          r_out1;
    logic [4*LANES-1:0]          r_out2;
    logic                        r_s1_valid;
    logic                        r_s2_valid;
    logic                        r_run;
    logic                        w_s2_en;
    logic                        w_in_ready;
    logic                        w_s1_load;
    logic                        w_s2_load;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        for (genvar j = 0; j < 4; j++) begin : g_bit
            for (genvar t = 0; t < 16; t++) begin : g_term
                assign w_term[n][j][t] = cms_term(2'(j), 4'(t),
                                                  in_sh1[4*n+3:4*n], in_sh2[4*n+3:4*n]);
            end
            assign w_c1[4*n+j] = ^r_term[n][j][7:0];
            assign w_c2[4*n+j] = ^r_term[n][j][15:8];
        end
    end

    // r_run keeps in_ready low during reset and until the first edge after release.
    assign w_s2_en    = !r_s2_valid || out_ready;
    assign w_in_ready = r_run && (!r_s1_valid || w_s2_en);
    assign w_s1_load  = in_valid && w_in_ready;
    assign w_s2_load  = r_s1_valid && w_s2_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_term     <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load) begin
                r_term <= w_term;
            end else if (STALL_KEEP == 0 && w_s2_load) begin
                r_term <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out1     <= '0;
            r_out2     <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
`ifdef PRINCE_SBOX_CMS_REFRESH_EN
                r_out1 <= w_c1 ^ rnd;
                r_out2 <= w_c2 ^ rnd;
`else
                r_out1 <= w_c1;
                r_out2 <= w_c2;
`endif
            end
        end
    end

`ifndef PRINCE_SBOX_CMS_REFRESH_EN
    logic w_unused_rnd;
    assign w_unused_rnd = ^rnd;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign out_sh1   = r_out1;
    assign out_sh2   = r_out2;

endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Directed self-checking bench for prince_sbox_cms_pipe (LANES=16, default build).
module tb_prince_sbox_cms_pipe;

    localparam int LANES = 16;
    localparam int W     = 4 * LANES;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_sh1;
    logic [W-1:0] in_sh2;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] rnd;
    logic [W-1:0] out_sh1;
    logic [W-1:0] out_sh2;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    prince_sbox_cms_pipe #(.LANES(LANES), .STALL_KEEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sh1    (in_sh1),
        .in_sh2    (in_sh2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rnd       (rnd),
        .out_sh1   (out_sh1),
        .out_sh2   (out_sh2),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] v);
        case (v)
            4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
            4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
            4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
            4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_vec(input logic [W-1:0] s1, input logic [W-1:0] s2);
        logic [W-1:0] r;
        for (int n = 0; n < LANES; n++) r[4*n +: 4] = sbox(s1[4*n +: 4] ^ s2[4*n +: 4]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
        in_valid = v;
        in_sh1   = {LANES{a}};
        in_sh2   = {LANES{b}};
    endtask

    task automatic send_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] e);
        @(negedge clk); drive(1'b1, a, b);
        @(negedge clk); in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_sh1 ^ out_sh2, {LANES{e}});
        @(negedge clk);
        chk({tag, "_lat3_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] expq[$];
        logic [W-1:0] s1v;
        logic [W-1:0] s2v;
        int sent;
        int got;
        int cyc;
        int first_cyc;
        int last_cyc;

        rst_n = 1'b0; out_ready = 1'b1; rnd = '0;
        drive(1'b0, 4'h0, 4'h0);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_sh1", out_sh1, 64'd0);
        chk("rst_out_sh2", out_sh2, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        send_one("zero", 4'h0, 4'h0, 4'hB);
        send_one("5_F", 4'h5, 4'hF, 4'h8);
        send_one("3_C", 4'h3, 4'hC, 4'h4);

        // all 256 share pairs per lane, back-to-back with random rnd
        sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
        while (got < 256 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("stream_extra", 64'(out_valid), 64'd0);
                end else begin
                    chk("stream_data", out_sh1 ^ out_sh2, expq.pop_front());
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            rnd = {$urandom, $urandom};
            if (sent < 256) begin
                chk("stream_in_ready", 64'(in_ready), 64'd1);
                for (int n = 0; n < LANES; n++) begin
                    s1v[4*n +: 4] = 4'(sent >> 4) ^ 4'(n);
                    s2v[4*n +: 4] = 4'(sent);
                end
                in_valid = 1'b1; in_sh1 = s1v; in_sh2 = s2v;
                expq.push_back(exp_vec(s1v, s2v));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("stream_count", 64'(got), 64'd256);
        chk("stream_span", 64'(last_cyc - first_cyc + 1), 64'd256);
        @(negedge clk);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // fill both stages, stall for 5 cycles, then release
        out_ready = 1'b0; drive(1'b1, 4'h1, 4'h2);
        @(negedge clk);
        chk("fill_ready1", 64'(in_ready), 64'd1);
        drive(1'b1, 4'h4, 4'hA);
        @(negedge clk);
        drive(1'b1, 4'h0, 4'h9);
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", out_sh1 ^ out_sh2, {LANES{4'h2}});
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 64'(out_valid), 64'd1);
        chk("release_data", out_sh1 ^ out_sh2, {LANES{4'hD}});
        @(negedge clk);
        chk("release_empty", 64'(out_valid), 64'd0);

        // asynchronous reset with two items in flight
        out_ready = 1'b0; drive(1'b1, 4'h6, 4'h3);
        @(negedge clk); drive(1'b1, 4'h7, 4'h7);
        @(negedge clk); in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_sh1", out_sh1, 64'd0);
        chk("arst_out_sh2", out_sh2, 64'd0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 64'(out_valid), 64'd0);
        end
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        send_one("post_rst", 4'hE, 4'h1, 4'h4);

`ifdef PRINCE_SBOX_CMS_REFRESH_EN
        begin
            logic [W-1:0] sh1_a;
            rnd = '0;
            send_one("refresh_r0", 4'h6, 4'h3, 4'hC);
            @(negedge clk); rnd = '0; drive(1'b1, 4'h6, 4'h3);
            @(negedge clk); in_valid = 1'b0;
            @(negedge clk); sh1_a = out_sh1;
            chk("refresh_a_data", out_sh1 ^ out_sh2, {LANES{4'hC}});
            @(negedge clk); rnd = {LANES{4'hF}}; drive(1'b1, 4'h6, 4'h3);
            @(negedge clk); in_valid = 1'b0;
            @(negedge clk);
            chk("refresh_b_data", out_sh1 ^ out_sh2, {LANES{4'hC}});
            chk("refresh_sh1_diff", sh1_a ^ out_sh1, {LANES{4'hF}});
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
